dmem_preload: RTL and testbench

- 8 x 8-bit data memory for the CPU data path. Sits directly downstream of the preset-data block, which drives constant bytes D0..D7.
- After reset, and on each reload request, a sequencer copies D0..D7 into the RAM, one byte per cycle.
- The CPU then reads and writes the RAM through a synchronous single port.
- ready tells the core when memory contents are valid.

---
 rtl/dmem_preload.sv | 132 +++++++++++++
 tb/tb_dmem_preload.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_preload.sv
// 8 x 8-bit data memory that fills itself from the preset bytes D0..D7 after reset
// or on reload, then serves the CPU through a synchronous single port.
module dmem_preload #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  input  logic [DW-1:0] D2,
  input  logic [DW-1:0] D3,
  input  logic [DW-1:0] D4,
  input  logic [DW-1:0] D5,
  input  logic [DW-1:0] D6,
  input  logic [DW-1:0] D7,
  input  logic          reload,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          access_err,
  output logic          dbg_state
);

  // CPU handshake: a request (we/re) is accepted on a rising edge only while
  // ready=1 and reload=0; otherwise it is dropped and, in LOAD, flagged on access_err.

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic          err_q, err_d;

  logic [DW-1:0] preset [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rd_en;

  assign preset[0] = D0;
  assign preset[1] = D1;
  assign preset[2] = D2;
  assign preset[3] = D3;
  assign preset[4] = D4;
  assign preset[5] = D5;
  assign preset[6] = D6;
  assign preset[7] = D7;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = preset[idx_q];
    rd_en     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_LOAD: begin
        err_d = we | re;
        if (reload) begin
          // restart the copy; nothing is written on the restart edge
          idx_d = '0;
        end else begin
          mem_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          if (idx_q == AW'(DEPTH - 1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (reload) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end else begin
          rd_en     = re;
          mem_we    = we;
          mem_waddr = addr;
          mem_wdata = wdata;
        end
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Read samples the pre-edge word, so a same-address write is read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
      if (rd_en) begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata      = rdata_q;
  assign ready      = (state_q == S_RUN);
  assign access_err = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_preload.sv
// Directed bench for dmem_preload: preload latency, CPU read/write, collision,
// access during load, reload and asynchronous reset mid-load.
module tb_dmem_preload;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_arr [8];
  logic       reload;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;
  logic       ready;
  logic       access_err;
  logic       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  dmem_preload dut (
    .clk        (clk),
    .rst        (rst),
    .D0         (d_arr[0]),
    .D1         (d_arr[1]),
    .D2         (d_arr[2]),
    .D3         (d_arr[3]),
    .D4         (d_arr[4]),
    .D5         (d_arr[5]),
    .D6         (d_arr[6]),
    .D7         (d_arr[7]),
    .reload     (reload),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .re         (re),
    .rdata      (rdata),
    .ready      (ready),
    .access_err (access_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    re   = 1'b1;
    exp_q.push_back(exp);
    tick();
    re = 1'b0;
    check($sformatf("read_a%0d", a), rdata, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] v);
    addr  = a;
    wdata = v;
    we    = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic count_load(input string tag);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("%s_ready_e%0d", tag, e), {7'd0, ready}, (e == 8) ? 8'd1 : 8'd0);
      check($sformatf("%s_err_e%0d", tag, e), {7'd0, access_err}, 8'd0);
    end
  endtask

  initial begin
    logic [7:0] preset_vals [8];
    preset_vals = '{8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h18, 8'h00};
    for (int i = 0; i < 8; i++) d_arr[i] = preset_vals[i];
    rst    = 1'b0;
    reload = 1'b0;
    addr   = '0;
    wdata  = '0;
    we     = 1'b0;
    re     = 1'b0;

    #2;
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_err", {7'd0, access_err}, 8'd0);
    check("rst_state", {7'd0, dbg_state}, 8'd0);

    // preload with an illegal write presented on the 2nd edge
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("load_ready_e%0d", e), {7'd0, ready}, (e == 8) ? 8'd1 : 8'd0);
      check($sformatf("load_err_e%0d", e), {7'd0, access_err}, (e == 2) ? 8'd1 : 8'd0);
      check($sformatf("load_rdata_e%0d", e), rdata, 8'h00);
      if (e == 1) begin
        addr  = 3'd0;
        wdata = 8'h77;
        we    = 1'b1;
      end else begin
        we = 1'b0;
      end
    end
    check("run_state", {7'd0, dbg_state}, 8'd1);
    for (int a = 0; a < 8; a++) do_read(3'(a), preset_vals[a]);

    // write then read
    do_write(3'd3, 8'h5A);
    check("run_err_after_wr", {7'd0, access_err}, 8'd0);
    do_read(3'd3, 8'h5A);
    do_read(3'd2, 8'h04);

    // same-address collision: read-before-write
    addr  = 3'd1;
    wdata = 8'hFF;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b0;
    check("collide_rdata", rdata, 8'hA8);
    do_read(3'd1, 8'hFF);

    // reload with a write presented on the reload edge
    do_write(3'd6, 8'h99);
    do_read(3'd6, 8'h99);
    reload = 1'b1;
    addr   = 3'd6;
    wdata  = 8'h11;
    we     = 1'b1;
    tick();
    reload = 1'b0;
    we     = 1'b0;
    check("reload_ready", {7'd0, ready}, 8'd0);
    check("reload_err", {7'd0, access_err}, 8'd0);
    check("reload_rdata_hold", rdata, 8'h99);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("reld_ready_e%0d", e), {7'd0, ready}, (e == 8) ? 8'd1 : 8'd0);
      check($sformatf("reld_err_e%0d", e), {7'd0, access_err}, 8'd0);
      // D0 changes after its own write edge and must not be captured
      if (e == 1) d_arr[0] = 8'hEE;
    end
    do_read(3'd6, 8'h18);
    do_read(3'd0, 8'h22);
    do_read(3'd1, 8'hA8);
    do_read(3'd3, 8'h03);

    // asynchronous reset between load edges 4 and 5
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", {7'd0, ready}, 8'd0);
    check("arst_rdata", rdata, 8'h00);
    check("arst_state", {7'd0, dbg_state}, 8'd0);
    d_arr[5] = 8'h5C;
    @(negedge clk);
    rst = 1'b1;
    count_load("arst");
    do_read(3'd0, 8'hEE);
    do_read(3'd5, 8'h5C);
    do_read(3'd6, 8'h18);
    do_read(3'd7, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
